divb_shift: RTL

DIVB_SHIFT -- requirements
Module: divb_shift

---
 rtl/divb_shift.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/divb_shift.sv
// divb_shift: signed restoring shift-subtract divider producing one quotient
// bit per clock (WIDTH CALC cycles per division).
// Optional feature macro: DIVB_SHIFT_REM_EN
//   defined   -> signed remainder is computed and registered
//   undefined -> remainder port reads as constant zero
module divb_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf,
  output logic             dz
);

  localparam int               CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] dsr;
  logic             neg_a;
  logic             neg_b;
  logic             b_zero;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] part_nxt;
  logic             last_step;
  logic             q_neg;
  logic [WIDTH-1:0] q_res;
  logic             ovf_res;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign a_mag = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign b_mag = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

  assign last_step = (state == CALC) && (cnt == LAST);
  assign q_neg     = neg_a ^ neg_b;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and status outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor magnitude if it fits.
  always_comb begin
    trial    = {part, dvd[WIDTH-1]};
    fits     = (trial >= {1'b0, dsr});
    diff     = trial[WIDTH-1:0] - dsr;
    part_nxt = fits ? diff : trial[WIDTH-1:0];
    dvd_nxt  = {dvd[WIDTH-2:0], fits};
  end

  // Signed quotient and flags from the final step, with saturation for
  // divide-by-zero and for the single overflowing case (MIN / -1).
  always_comb begin
    q_res   = q_neg ? (~dvd_nxt + WIDTH'(1)) : dvd_nxt;
    ovf_res = 1'b0;
    if (b_zero) begin
      q_res   = neg_a ? MIN_NEG : MAX_POS;
      ovf_res = 1'b1;
    end else if (!q_neg && dvd_nxt[WIDTH-1]) begin
      q_res   = MAX_POS;
      ovf_res = 1'b1;
    end
  end

  // Operand capture, iteration, and result registers (loaded entering DONE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      dvd      <= '0;
      part     <= '0;
      dsr      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
      quotient <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cnt    <= '0;
        dvd    <= a_mag;
        part   <= '0;
        dsr    <= b_mag;
        neg_a  <= A[WIDTH-1];
        neg_b  <= B[WIDTH-1];
        b_zero <= (B == '0);
      end else if (state == CALC) begin
        cnt  <= cnt + CW'(1);
        dvd  <= dvd_nxt;
        part <= part_nxt;
      end
      if (last_step) begin
        quotient <= q_res;
        ovf      <= ovf_res;
        dz       <= b_zero;
      end
    end
  end

`ifdef DIVB_SHIFT_REM_EN
  logic [WIDTH-1:0] a_hold;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] rem_q;

  // Remainder takes the dividend's sign; on divide-by-zero it is the dividend.
  always_comb begin
    r_res = neg_a ? (~part_nxt + WIDTH'(1)) : part_nxt;
    if (b_zero) r_res = a_hold;
  end

  // Dividend copy for the divide-by-zero case and the remainder register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_hold <= '0;
      rem_q  <= '0;
    end else begin
      if (state == IDLE && start) a_hold <= A;
      if (last_step)              rem_q  <= r_res;
    end
  end

  assign remainder = rem_q;
`else
  assign remainder = '0;
`endif

endmodule
